// File: rtl/char_buffer_ctrl.sv
// Write controller for the 16x16 character RAM: round-robin intake from two requesters,
// FIFO buffering, commits only during vertical blanking, and a multi-frame full-screen clear.
module char_buffer_ctrl #(
  parameter int         FIFO_DEPTH = 4,
  parameter logic [6:0] CLEAR_CHAR = 7'h20
) (
  input  logic       pclk,
  input  logic       rst_n,
  input  logic       vblnk_in,
  input  logic       req0_valid,
  input  logic [7:0] req0_addr,
  input  logic [6:0] req0_data,
  output logic       req0_ready,
  input  logic       req1_valid,
  input  logic [7:0] req1_addr,
  input  logic [6:0] req1_data,
  output logic       req1_ready,
  input  logic       clear_req,
  output logic       clear_busy,
  output logic       ram_we,
  output logic [7:0] ram_addr,
  output logic [6:0] ram_wdata,
  output logic       fsm_state
);

  localparam int AW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic {IDLE = 1'b0, CLEAR = 1'b1} state_t;

  state_t          state_q, state_d;
  logic [14:0]     mem [FIFO_DEPTH];
  logic [AW-1:0]   wr_ptr, rd_ptr;
  logic [CW-1:0]   count;
  logic [7:0]      clr_cnt;
  logic            last_grant;

  logic            not_full, both_valid, push0, push1, push, pop, clr_step, clr_start;
  logic [14:0]     push_word, head;

  // Handshake: a requester's write transfers on the pclk edge where its valid && ready
  // are both high; addr/data must be stable while valid is high.
  assign not_full   = (count < CW'(FIFO_DEPTH)) && (state_q == IDLE);
  assign both_valid = req0_valid && req1_valid;
  assign req0_ready = rst_n && not_full && (!both_valid || last_grant);
  assign req1_ready = rst_n && not_full && (!both_valid || !last_grant);

  assign push0     = req0_valid && req0_ready;
  assign push1     = req1_valid && req1_ready;
  assign push      = push0 || push1;
  assign push_word = push0 ? {req0_addr, req0_data} : {req1_addr, req1_data};
  assign head      = mem[rd_ptr];

  // A clear request in IDLE wins over draining in the same cycle.
  assign clr_start = (state_q == IDLE) && clear_req;
  assign pop       = (state_q == IDLE) && !clear_req && vblnk_in && (count != '0);
  assign clr_step  = (state_q == CLEAR) && vblnk_in;

  assign clear_busy = (state_q == CLEAR);
  assign fsm_state  = (state_q == CLEAR);

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (clear_req) state_d = CLEAR;
      CLEAR:   if (clr_step && (clr_cnt == 8'hFF)) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Storage array carries no reset; validity is tracked by count.
  always_ff @(posedge pclk) begin
    if (push) mem[wr_ptr] <= push_word;
  end

  always_ff @(posedge pclk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      count      <= '0;
      last_grant <= 1'b1;
      clr_cnt    <= '0;
      ram_we     <= 1'b0;
      ram_addr   <= '0;
      ram_wdata  <= '0;
    end else begin
      if (push) begin
        wr_ptr     <= wr_ptr + AW'(1);
        last_grant <= push1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      case ({push, pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase

      if (clr_start)     clr_cnt <= '0;
      else if (clr_step) clr_cnt <= clr_cnt + 8'd1;

      if (pop) begin
        ram_we    <= 1'b1;
        ram_addr  <= head[14:7];
        ram_wdata <= head[6:0];
      end else if (clr_step) begin
        ram_we    <= 1'b1;
        ram_addr  <= clr_cnt;
        ram_wdata <= CLEAR_CHAR;
      end else begin
        ram_we    <= 1'b0;
      end
    end
  end

endmodule
